// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment hex driver with frame-aligned display updates.
// Optional leading-zero blanking is compiled in with `define SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  enable,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000011;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1010011;
      4'h5: s = 7'b1011110;
      4'h6: s = 7'b1111110;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1011111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111010;
      4'hC: s = 7'b0111100;
      4'hD: s = 7'b1101011;
      4'hE: s = 7'b1111100;
      default: s = 7'b1110100;
    endcase
    return s;
  endfunction

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   disp_val_q, disp_val_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                  pend_v_q, pend_v_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     sel_q, sel_d;
  logic                  fd_q, fd_d;
  logic                  tick, wrap;
  logic [3:0]            nib;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic                  zero_run;
  logic [DIGITS-1:0]     blank;
`endif

  always_comb begin
    tick = enable && (cnt_q == CNT_MAX);
    wrap = tick && (idx_q == IDX_MAX);

    cnt_d = cnt_q;
    if (tick)        cnt_d = '0;
    else if (enable) cnt_d = cnt_q + CW'(1);

    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);

    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_v_d   = pend_v_q;
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_mask;
      pend_v_d   = 1'b1;
    end
    if (wrap) pend_v_d = 1'b0;

    // A load landing on the wrap edge bypasses the pending register.
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    if (wrap) begin
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_mask;
      end else if (pend_v_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
    end

    // Outputs are built from next-state so a coincident load shows immediately.
    nib = disp_val_d[4*int'(idx_d) +: 4];
    seg_d = '0;
    dp_d  = 1'b0;
    sel_d = '0;
    if (enable) begin
      seg_d        = enc(nib);
      dp_d         = disp_dp_d[idx_d];
      sel_d[idx_d] = 1'b1;
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    zero_run = 1'b1;
    blank    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (disp_val_d[4*i +: 4] == 4'h0);
      blank[i] = zero_run;
    end
    if (blank[idx_d]) seg_d = '0;
`endif

    fd_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_v_q   <= 1'b0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      sel_q      <= '0;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_v_q   <= pend_v_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      sel_q      <= sel_d;
      fd_q       <= fd_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign dig_sel    = sel_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display at DIGITS=4, SCAN_DIV=4 (16-cycle frames).
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_mask;
  logic        enable;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  seg_scan_display #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_mask(dp_mask),
    .enable(enable), .seg_out(seg_out), .dp_out(dp_out), .dig_sel(dig_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b0000000;
`else
  localparam logic [6:0] LZ = 7'b0111111;
`endif
  localparam logic [3:0][6:0] S_1A3F = {7'b0000011, 7'b1110111, 7'b1001111, 7'b1110100};
  localparam logic [3:0][6:0] S_CCCC = {4{7'b0111100}};
  localparam logic [3:0][6:0] S_0050 = {LZ, LZ, 7'b1011110, 7'b0111111};
  localparam logic [3:0][6:0] S_0000 = {LZ, LZ, LZ, 7'b0111111};
  localparam logic [3:0][6:0] S_0007 = {LZ, LZ, LZ, 7'b0000111};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_digit(input string tag, input int d, input logic [3:0][6:0] segs,
                           input logic [3:0] dpm);
    chk({tag, "_sel"}, 32'(dig_sel), 32'(1) << d);
    chk({tag, "_seg"}, 32'(seg_out), 32'(segs[d]));
    chk({tag, "_dp"},  32'(dp_out),  32'(dpm[d]));
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_sel"}, 32'(dig_sel), 0);
    chk({tag, "_seg"}, 32'(seg_out), 0);
    chk({tag, "_dp"},  32'(dp_out),  0);
    chk({tag, "_fd"},  32'(frame_done), 0);
  endtask

  task automatic wait_frame_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 200);
    chk("wait_fd", 32'(frame_done), 1);
  endtask

  // Entered at the negedge of a frame's first cycle; returns at the next frame's first cycle.
  task automatic check_frame(input string tag, input logic [3:0][6:0] segs, input logic [3:0] dpm,
                             input int lc0, input logic [15:0] lv0,
                             input int lc1, input logic [15:0] lv1, input logic [3:0] ldp);
    for (int c = 0; c < 16; c++) begin
      chk_digit(tag, c / 4, segs, dpm);
      chk({tag, "_fd"}, 32'(frame_done), 32'(c == 0));
      load = 1'b0;
      if (c == lc0) begin load = 1'b1; value = lv0; dp_mask = ldp; end
      if (c == lc1) begin load = 1'b1; value = lv1; dp_mask = ldp; end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; load = 1'b0; value = '0; dp_mask = '0;
    repeat (3) @(negedge clk);
    chk_blank("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_digit("release", 0, S_0000, 4'b0000);
    chk("release_fd", 32'(frame_done), 0);

    value = 16'h1A3F; dp_mask = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_frame_done();

    // Two loads in one frame: current frame intact, only the last one appears next.
    check_frame("scan", S_1A3F, 4'b0000, 2, 16'hBBBB, 5, 16'hCCCC, 4'b0000);
    check_frame("upd",  S_CCCC, 4'b0000, 0, 16'h0050, -1, 16'h0, 4'b1010);

    for (int c = 0; c <= 8; c++) begin
      chk_digit("lz", c / 4, S_0050, 4'b1010);
      if (c == 0) chk("lz_fd", 32'(frame_done), 1);
      if (c < 8) @(negedge clk);
    end
    enable = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chk_blank("frozen");
      if (j == 10) enable = 1'b1;
    end
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      chk_digit("resume", 2, S_0050, 4'b1010);
    end
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk_digit("after", 3, S_0050, 4'b1010);
      chk("after_fd", 32'(frame_done), 0);
    end
    @(negedge clk);
    chk("resume_fd", 32'(frame_done), 1);
    chk_digit("resume_f0", 0, S_0050, 4'b1010);

    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk_digit("prerst", c / 4, S_0050, 4'b1010);
      load = (c == 1);
      if (c == 1) begin value = 16'h8888; dp_mask = 4'b1111; end
    end
    load = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_blank("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_digit("postrst", 0, S_0000, 4'b0000);
    chk("postrst_fd", 32'(frame_done), 0);
    wait_frame_done();

    check_frame("cleared", S_0000, 4'b0000, 15, 16'h0007, -1, 16'h0, 4'b0001);
    check_frame("coinc",   S_0007, 4'b0001, -1, 16'h0, -1, 16'h0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
